l2_arb_ctrl: RTL

L2_ARB_CTRL -- requirements
Module: l2_arb_ctrl

---
 rtl/l2_arb_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/l2_arb_ctrl.sv
// l2_arb_ctrl
//   Two-requester round-robin arbiter in front of an L2 cache and its backing
//   memory. A winning L1 miss gets a lookup in the L2. A hit is answered with
//   the L2 data. A miss is filled from memory through a req/ack handshake.
//   Every output comes straight from a flop.
//
// Build option:
//   L2_ARB_TIMEOUT_EN - when defined, a down-counter bounds the MEM_WAIT
//   state to MEM_TIMEOUT cycles. On expiry the fill is abandoned and an error
//   response is returned (rsp_err=1, rsp_data=0). When not defined, MEM_WAIT
//   waits for mem_ack indefinitely and rsp_err is tied low.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req0/req1, addr0/addr1   L1 miss requests (held until granted) + address
//   gnt0/gnt1                one-cycle grant pulses
//   rsp_valid/id/data/err    one-cycle response strobe, target, data, abort
//   l2_lookup, l2_addr       L2 lookup strobe and address
//   l2_hit, l2_miss, l2_data L2 result, valid the cycle after l2_lookup
//   mem_req, mem_addr        memory fill request, held until mem_ack
//   mem_ack, mem_data        memory fill acknowledge and data
//   busy                     high whenever the FSM is not in IDLE
//
// State     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a request; arbitrates and grants
// LOOKUP    | grant and l2_lookup pulses are visible for this one cycle
// CHECK     | L2 result sampled; a hit goes to RESP, anything else to MEM_WAIT
// MEM_WAIT  | mem_req held high until mem_ack (or until the timeout expires)
// RESP      | rsp_valid is high for this one cycle
module l2_arb_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              l2_lookup,
  output logic [ADDR_W-1:0] l2_addr,
  input  logic              l2_hit,
  input  logic              l2_miss,
  input  logic [DATA_W-1:0] l2_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
);

  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("l2_arb_ctrl: MEM_TIMEOUT must be within 2..255");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    CHECK    = 3'd2,
    MEM_WAIT = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_ptr;       // requester favoured when both request
  logic                r_id;        // requester owning the current transaction
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_lookup;
  logic                r_mem_req;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_addr;      // shared by the L2 and memory address ports
  logic [DATA_W-1:0]   r_rsp_data;
  logic                w_win;

`ifdef L2_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LOAD = 8'(MEM_TIMEOUT - 1);
  logic [7:0] r_tmo;
  logic       r_rsp_err;
`endif

  always_comb begin
    w_win = req1;
    if (req0 && req1) begin
      w_win = r_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_id        <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_lookup    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_busy      <= 1'b0;
      r_addr      <= '0;
      r_rsp_data  <= '0;
`ifdef L2_ARB_TIMEOUT_EN
      r_tmo       <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req0 || req1) begin
            r_id     <= w_win;
            r_addr   <= w_win ? addr1 : addr0;
            r_gnt0   <= ~w_win;
            r_gnt1   <= w_win;
            r_lookup <= 1'b1;
            r_ptr    <= ~w_win;
            r_busy   <= 1'b1;
            r_state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          r_lookup <= 1'b0;
          r_state  <= CHECK;
        end
        CHECK: begin
          // Hit wins over miss. A missing L2 answer is handled as a miss so
          // that the request is still served from memory.
          casez ({l2_hit, l2_miss})
            2'b1?: begin
              r_rsp_valid <= 1'b1;
              r_rsp_id    <= r_id;
              r_rsp_data  <= l2_data;
              r_state     <= RESP;
            end
            default: begin
              r_mem_req <= 1'b1;
`ifdef L2_ARB_TIMEOUT_EN
              r_tmo     <= TMO_LOAD;
`endif
              r_state   <= MEM_WAIT;
            end
          endcase
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            r_mem_req   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= mem_data;
            r_state     <= RESP;
          end
`ifdef L2_ARB_TIMEOUT_EN
          // The counter reaches zero on the last allowed MEM_WAIT cycle.
          // An ack arriving on that same cycle is still taken.
          else if (r_tmo == 8'd0) begin
            r_mem_req   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_tmo <= r_tmo - 8'd1;
          end
`endif
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_id    <= 1'b0;
          r_rsp_data  <= '0;
`ifdef L2_ARB_TIMEOUT_EN
          r_rsp_err   <= 1'b0;
`endif
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign l2_lookup = r_lookup;
  assign l2_addr   = r_addr;
  assign mem_addr  = r_addr;
  assign mem_req   = r_mem_req;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;
`ifdef L2_ARB_TIMEOUT_EN
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
